// File: rtl/multisim_client_pull_mc.sv
// ============================================================================
// Module   : multisim_client_pull_mc
// Purpose  : Multi-channel multisim pull client. It prefetches words from
//            NUM_CHANNELS servers into per-channel FIFOs, so a consumer can
//            take one word per cycle per channel. The optional statistics
//            ports are enabled by defining MULTISIM_CLIENT_PULL_STATS_EN.
//            The package below provides behavioural server entry points
//            with the multisim client call signatures.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multisim_client_pull_mc_pkg;

    localparam int MAX_W = 1024;

`ifdef MULTISIM_SIMULATION_4_STATE
    typedef logic multisim_data_t;
`else
    typedef bit multisim_data_t;
`endif

    // Server model state: a word is valid on every g_valid_period-th call per server
    int unsigned g_valid_period = 1;
    int unsigned g_calls_total  = 0;
    int unsigned g_starts       = 0;
    string       g_last_dir     = "";
    int unsigned g_calls [string];
    int unsigned g_words [string];

    function automatic void multisim_stub_reset();
        g_calls.delete();
        g_words.delete();
        g_calls_total = 0;
        g_starts      = 0;
    endfunction

    function automatic void multisim_client_start(input string server_runtime_directory,
                                                  input string server_name);
        g_last_dir = server_runtime_directory;
        if (!g_words.exists(server_name)) begin
            g_words[server_name] = 0;
            g_calls[server_name] = 0;
        end
        g_starts = g_starts + 1;
    endfunction

    function automatic int multisim_client_pull_packed(input string server_name,
                                                       output logic [MAX_W-1:0] data);
        int unsigned n;
        n = g_calls[server_name] + 1;
        g_calls[server_name] = n;
        g_calls_total = g_calls_total + 1;
        data = '0;
        if (g_valid_period != 0 && (n % g_valid_period) == 0) begin
            g_words[server_name] = g_words[server_name] + 1;
            data = MAX_W'(g_words[server_name]);
            return 1;
        end
        return 0;
    endfunction

endpackage

module multisim_client_pull_mc
    import multisim_client_pull_mc_pkg::*;
#(
    parameter string SERVER_RUNTIME_DIRECTORY = "../output_top",
    parameter int    NUM_CHANNELS             = 4,
    parameter int    DATA_WIDTH               = 64,
    parameter int    FIFO_DEPTH               = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  string                                              server_name,
    input  logic [NUM_CHANNELS-1:0]                            data_rdy,
    output logic [NUM_CHANNELS-1:0]                            data_vld,
    output multisim_data_t [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  data,
    output logic [NUM_CHANNELS-1:0][$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
`ifdef MULTISIM_CLIENT_PULL_STATS_EN
    ,
    output logic [NUM_CHANNELS-1:0][31:0]                      stat_words,
    output logic [NUM_CHANNELS-1:0][31:0]                      stat_stalls
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic                              r_started;
    logic [LW-1:0]                     r_level  [NUM_CHANNELS];
    logic [PW-1:0]                     r_wr_ptr [NUM_CHANNELS];
    logic [PW-1:0]                     r_rd_ptr [NUM_CHANNELS];
    multisim_data_t [DATA_WIDTH-1:0]   r_mem    [NUM_CHANNELS][FIFO_DEPTH];
`ifdef MULTISIM_CLIENT_PULL_STATS_EN
    logic [31:0]                       r_stat_words  [NUM_CHANNELS];
    logic [31:0]                       r_stat_stalls [NUM_CHANNELS];
`endif

    // One process owns every channel so server calls happen in channel order
    always_ff @(posedge clk or negedge rst_n) begin
        logic             v_pop;
        logic             v_push;
        int               v_ret;
        logic [MAX_W-1:0] v_word;
        if (!rst_n) begin
            r_started <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_level[c]  <= '0;
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                for (int d = 0; d < FIFO_DEPTH; d++) begin
                    r_mem[c][d] <= '0;
                end
`ifdef MULTISIM_CLIENT_PULL_STATS_EN
                r_stat_words[c]  <= '0;
                r_stat_stalls[c] <= '0;
`endif
            end
        end else if (!r_started) begin
`ifdef MULTISIM_EMULATION
            if (1'b1) begin
`else
            if (server_name != "") begin
`endif
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    multisim_client_start(SERVER_RUNTIME_DIRECTORY,
                                          $sformatf("%s_%0d", server_name, c));
                end
                r_started <= 1'b1;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                v_pop  = (r_level[c] != '0) && data_rdy[c];
                v_push = 1'b0;
                v_word = '0;
                // A full FIFO that is popping this edge still has room for one pull
                if ((r_level[c] < LW'(FIFO_DEPTH)) || v_pop) begin
                    v_ret  = multisim_client_pull_packed($sformatf("%s_%0d", server_name, c),
                                                         v_word);
                    v_push = v_ret[0];
                end
                if (v_push) begin
                    r_mem[c][r_wr_ptr[c]] <= DATA_WIDTH'(v_word);
                    r_wr_ptr[c]           <= r_wr_ptr[c] + 1'b1;
                end
                if (v_pop) begin
                    r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                end
                r_level[c] <= r_level[c] + LW'(v_push) - LW'(v_pop);
`ifdef MULTISIM_CLIENT_PULL_STATS_EN
                if (v_push && r_stat_words[c] != 32'hFFFF_FFFF) begin
                    r_stat_words[c] <= r_stat_words[c] + 32'd1;
                end
                if ((r_level[c] == '0) && data_rdy[c] && r_stat_stalls[c] != 32'hFFFF_FFFF) begin
                    r_stat_stalls[c] <= r_stat_stalls[c] + 32'd1;
                end
`endif
            end
        end
    end

    always_comb begin
        data_vld   = '0;
        data       = '0;
        fifo_level = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            data_vld[c]   = (r_level[c] != '0);
            data[c]       = r_mem[c][r_rd_ptr[c]];
            fifo_level[c] = r_level[c];
        end
    end

`ifdef MULTISIM_CLIENT_PULL_STATS_EN
    always_comb begin
        stat_words  = '0;
        stat_stalls = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            stat_words[c]  = r_stat_words[c];
            stat_stalls[c] = r_stat_stalls[c];
        end
    end

    final begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            $display("multisim_client_pull_mc channel %0d: words=%0d stalls=%0d",
                     c, r_stat_words[c], r_stat_stalls[c]);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_multisim_client_pull_mc.sv
// ============================================================================
// Module   : tb_multisim_client_pull_mc
// Purpose  : Directed self-checking bench for multisim_client_pull_mc
//            (two channels, 16-bit words, 4-deep FIFOs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multisim_client_pull_mc;

    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int FD  = 4;
    localparam int LW  = $clog2(FD+1);

    logic                          clk;
    logic                          rst_n;
    string                         server_name;
    logic [NCH-1:0]                data_rdy;
    logic [NCH-1:0]                data_vld;
    logic [NCH-1:0][DW-1:0]        data;
    logic [NCH-1:0][LW-1:0]        fifo_level;
`ifdef MULTISIM_CLIENT_PULL_STATS_EN
    logic [NCH-1:0][31:0]          stat_words;
    logic [NCH-1:0][31:0]          stat_stalls;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    multisim_client_pull_mc #(
        .SERVER_RUNTIME_DIRECTORY ("../output_top"),
        .NUM_CHANNELS             (NCH),
        .DATA_WIDTH               (DW),
        .FIFO_DEPTH               (FD)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .server_name (server_name),
        .data_rdy    (data_rdy),
        .data_vld    (data_vld),
        .data        (data),
        .fifo_level  (fifo_level)
`ifdef MULTISIM_CLIENT_PULL_STATS_EN
        ,
        .stat_words  (stat_words),
        .stat_stalls (stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic found;
        rst_n       = 1'b0;
        server_name = "";
        data_rdy    = '0;
        multisim_client_pull_mc_pkg::g_valid_period = 1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_vld", 64'(data_vld), 64'd0);
        chk("reset_level", 64'(fifo_level), 64'd0);
        chk("reset_data", 64'(data), 64'd0);

        // No start and no pulls while the server name is empty
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("nostart_calls", 64'(multisim_client_pull_mc_pkg::g_calls_total), 64'd0);
        chk("nostart_vld", 64'(data_vld), 64'd0);

        // First edge starts both servers, second edge pulls word 1
        server_name = "srv";
        @(negedge clk);
        chk("start_count", 64'(multisim_client_pull_mc_pkg::g_starts), 64'd2);
        chk("start_names", 64'(multisim_client_pull_mc_pkg::g_words.exists("srv_0") &&
                               multisim_client_pull_mc_pkg::g_words.exists("srv_1")), 64'd1);
        chk("start_no_pull", 64'(multisim_client_pull_mc_pkg::g_calls_total), 64'd0);
        @(negedge clk);
        chk("first_vld", 64'(data_vld), 64'd3);
        chk("first_data0", 64'(data[0]), 64'd1);
        chk("first_data1", 64'(data[1]), 64'd1);
        chk("first_level", 64'(fifo_level), {60'd0, 2'd0, 1'b0, 1'b0} | 64'h9);

        // Back-pressure: FIFO fills to 4, then pulls stop
        repeat (8) @(negedge clk);
        chk("full_level", 64'(fifo_level), 64'h24);
        chk("full_head", 64'(data[0]), 64'd1);
        chk("full_calls", 64'(multisim_client_pull_mc_pkg::g_calls_total), 64'd8);

        // Release: full FIFO pops and pulls on the same edge, words in order
        data_rdy = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("stream_data0", 64'(data[0]), 64'(2 + k));
            chk("stream_data1", 64'(data[1]), 64'(2 + k));
            chk("stream_lvl_vld", {56'd0, 64'(fifo_level), 2'(data_vld)} >> 0, {58'd0, 6'h24, 2'd3});
        end
        chk("stream_calls", 64'(multisim_client_pull_mc_pkg::g_calls_total), 64'd20);

        // Invalid pull while popping drops the level to 3
        multisim_client_pull_mc_pkg::g_valid_period = 1000;
        @(negedge clk);
        chk("drain_level", 64'(fifo_level), 64'h1B);
        chk("drain_data0", 64'(data[0]), 64'd8);
        chk("drain_calls", 64'(multisim_client_pull_mc_pkg::g_calls_total), 64'd22);

        // Asynchronous reset mid-cycle clears outputs at once
        #2 rst_n = 1'b0;
        #1;
        chk("async_vld", 64'(data_vld), 64'd0);
        chk("async_level", 64'(fifo_level), 64'd0);
        chk("async_data", 64'(data), 64'd0);
        repeat (3) @(negedge clk);
        chk("reset_no_calls", 64'(multisim_client_pull_mc_pkg::g_calls_total), 64'd22);

        // After release the next server word (11) appears; buffered 8..10 are lost
        multisim_client_pull_mc_pkg::g_valid_period = 1;
        data_rdy = 2'b00;
        rst_n    = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (data_vld == 2'b11) found = 1'b1;
        end
        chk("resume_seen", 64'(found), 64'd1);
        chk("resume_data0", 64'(data[0]), 64'd11);
        chk("resume_data1", 64'(data[1]), 64'd11);

        // Server valid on every 3rd call with rdy=1: vld pulses 1 cycle in 3
        rst_n = 1'b0;
        multisim_client_pull_mc_pkg::multisim_stub_reset();
        multisim_client_pull_mc_pkg::g_valid_period = 3;
        data_rdy = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            if (j == 4 || j == 7) begin
                chk("sparse_vld", 64'(data_vld), 64'd3);
                chk("sparse_data", 64'(data[0]), 64'((j - 1) / 3));
            end else begin
                chk("sparse_idle", 64'(data_vld), 64'd0);
            end
        end

        // Channels are independent: channel 1 stalls and fills, channel 0 streams
        multisim_client_pull_mc_pkg::g_valid_period = 1;
        data_rdy = 2'b01;
        repeat (6) @(negedge clk);
        chk("indep_level", 64'(fifo_level), 64'h21);
        chk("indep_data0", 64'(data[0]), 64'd8);
        chk("indep_data1", 64'(data[1]), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
